// File: rtl/phase_acc_pkg.sv
// Shared constants for the multi-channel NCO phase accumulator: register map,
// default widths and the channel-index width helper.
package phase_acc_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 12;

    localparam logic [1:0] ADDR_FREQ0  = 2'd0;
    localparam logic [1:0] ADDR_FREQ1  = 2'd1;
    localparam logic [1:0] ADDR_PHASE0 = 2'd2;
    localparam logic [1:0] ADDR_PHASE1 = 2'd3;

    // Channel select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int nch);
        if (nch > 1) begin
            return $clog2(nch);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/phase_acc_chan.sv
// One NCO channel: shadow/active profile registers, phase accumulator with
// carry-out wrap flag, and the truncate-plus-offset output stage.
module phase_acc_chan
    import phase_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_wr_en,
    input  logic [1:0]       i_wr_addr,
    input  logic [ACC_W-1:0] i_wr_data,
    input  logic             i_commit,
    input  logic             i_freq_sel,
    input  logic             i_phase_sel,
    input  logic             i_clr,
    output logic [OUT_W-1:0] o_phase,
    output logic             o_wrap
);

    logic [ACC_W-1:0] r_sh_freq0, r_sh_freq1, r_act_freq0, r_act_freq1;
    logic [OUT_W-1:0] r_sh_phase0, r_sh_phase1, r_act_phase0, r_act_phase1;
    logic [ACC_W-1:0] w_nx_freq0, w_nx_freq1;
    logic [OUT_W-1:0] w_nx_phase0, w_nx_phase1;
    logic [ACC_W-1:0] w_freq;
    logic [OUT_W-1:0] w_phase;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] r_acc;
    logic             r_wrap;
    logic [OUT_W-1:0] r_phase;

    // Shadow contents including this cycle's write, so a same-cycle commit picks it up.
    assign w_nx_freq0  = (i_wr_en && (i_wr_addr == ADDR_FREQ0))  ? i_wr_data : r_sh_freq0;
    assign w_nx_freq1  = (i_wr_en && (i_wr_addr == ADDR_FREQ1))  ? i_wr_data : r_sh_freq1;
    assign w_nx_phase0 = (i_wr_en && (i_wr_addr == ADDR_PHASE0)) ? i_wr_data[OUT_W-1:0] : r_sh_phase0;
    assign w_nx_phase1 = (i_wr_en && (i_wr_addr == ADDR_PHASE1)) ? i_wr_data[OUT_W-1:0] : r_sh_phase1;

    assign w_freq  = i_freq_sel  ? r_act_freq1  : r_act_freq0;
    assign w_phase = i_phase_sel ? r_act_phase1 : r_act_phase0;
    assign w_sum   = {1'b0, r_acc} + {1'b0, w_freq};

    // Shadow and active profile registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh_freq0   <= '0;
            r_sh_freq1   <= '0;
            r_sh_phase0  <= '0;
            r_sh_phase1  <= '0;
            r_act_freq0  <= '0;
            r_act_freq1  <= '0;
            r_act_phase0 <= '0;
            r_act_phase1 <= '0;
        end else begin
            r_sh_freq0  <= w_nx_freq0;
            r_sh_freq1  <= w_nx_freq1;
            r_sh_phase0 <= w_nx_phase0;
            r_sh_phase1 <= w_nx_phase1;
            if (i_commit) begin
                r_act_freq0  <= w_nx_freq0;
                r_act_freq1  <= w_nx_freq1;
                r_act_phase0 <= w_nx_phase0;
                r_act_phase1 <= w_nx_phase1;
            end
        end
    end

    // Stage 1: accumulator and carry-out flag.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_acc  <= '0;
            r_wrap <= 1'b0;
        end else if (i_enable) begin
            r_acc  <= w_sum[ACC_W-1:0];
            r_wrap <= w_sum[ACC_W];
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Stage 2: truncated phase plus offset; runs every cycle so offsets show while idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_acc[ACC_W-1 -: OUT_W] + w_phase;
        end
    end

    assign o_phase = r_phase;
    assign o_wrap  = r_wrap;

endmodule

// File: rtl/phase_acc_nco.sv
// Multi-channel NCO phase accumulator top: write decode, commit fan-out to
// every channel and the out_valid pipeline.
module phase_acc_nco
    import phase_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int NCH   = 2,
    localparam int CH_W = ch_w(NCH)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_wr_en,
    input  logic [CH_W-1:0]    i_wr_chan,
    input  logic [1:0]         i_wr_addr,
    input  logic [ACC_W-1:0]   i_wr_data,
    input  logic               i_commit,
    input  logic [NCH-1:0]     i_freq_sel,
    input  logic [NCH-1:0]     i_phase_sel,
    input  logic [NCH-1:0]     i_clr,
    output logic [NCH*OUT_W-1:0] o_phase_out,
    output logic [NCH-1:0]     o_wrap,
    output logic               o_out_valid
);

    logic r_en_d;
    logic r_out_valid;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        logic w_wr_hit;
        // Out-of-range channel numbers match no instance and are dropped.
        assign w_wr_hit = i_wr_en && (i_wr_chan == CH_W'(c));

        phase_acc_chan #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_chan (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_enable    (i_enable),
            .i_wr_en     (w_wr_hit),
            .i_wr_addr   (i_wr_addr),
            .i_wr_data   (i_wr_data),
            .i_commit    (i_commit),
            .i_freq_sel  (i_freq_sel[c]),
            .i_phase_sel (i_phase_sel[c]),
            .i_clr       (i_clr[c]),
            .o_phase     (o_phase_out[c*OUT_W +: OUT_W]),
            .o_wrap      (o_wrap[c])
        );
    end

    // Enable follows the two-stage datapath so out_valid lines up with phase_out.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_en_d      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_en_d      <= i_enable;
            r_out_valid <= r_en_d;
        end
    end

    assign o_out_valid = r_out_valid;

endmodule
